// File: rtl/serdes_pkg.sv
// +-----------------------------------------------------------------------------+
// | serdes_pkg : shared FSM state type and counter sizing for serializer and    |
// |              deserializer blocks                                            |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package serdes_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  function automatic int cnt_w(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

  // A serializer feeding a deserializer only frames correctly when both use the same WIDTH.
  function automatic bit width_match(input int ser_width, input int des_width);
    return ser_width == des_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_serializer_if.sv
// +-----------------------------------------------------------------------------+
// | piso_serializer_if : parallel word handshake plus serial output bundle      |
// | Revision           : 1.0                                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_en;
  logic             frame_last;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_en,
    input  frame_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ser_out,
    output ser_valid,
    output ser_en,
    output frame_last
  );
endinterface

`default_nettype wire

// File: rtl/serdes_bit_cnt.sv
// +-----------------------------------------------------------------------------+
// | serdes_bit_cnt : 0..WIDTH-1 bit position counter with clear and enable,     |
// |                  flags the final bit position                               |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module serdes_bit_cnt
  import serdes_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_last
);

  localparam int              c_cnt_w = cnt_w(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  // Saturates at the final position; only a clear starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign o_last = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// +-----------------------------------------------------------------------------+
// | piso_serializer : valid/ready parallel word in, one bit per tick out, with  |
// |                   clock enable for the downstream serial-in register        |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         tick,
  piso_serializer_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_shifted;
  logic             w_ser_bit;
  logic             w_last;
  logic             w_in_shift;
  logic             w_done;
  logic             w_ready;
  logic             w_load;
  logic             w_shift;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_done     = w_in_shift & tick & w_last;
  assign w_ready    = (r_state == ST_IDLE) | w_done;
  assign w_load     = bus.in_valid & w_ready;
  assign w_shift    = w_in_shift & tick & ~w_last;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_ser_bit       = r_shreg[WIDTH-1];
      assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_ser_bit       = r_shreg[0];
      assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  serdes_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_load | w_done),
    .i_en   (w_shift),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_done && !w_load) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Serial outputs come only from registered state, so reset clears them at once.
  always_comb begin
    bus.in_ready   = w_ready;
    bus.ser_valid  = 1'b0;
    bus.ser_out    = 1'b0;
    bus.ser_en     = 1'b0;
    bus.frame_last = 1'b0;
    if (w_in_shift) begin
      bus.ser_valid  = 1'b1;
      bus.ser_out    = w_ser_bit;
      bus.ser_en     = tick;
      bus.frame_last = w_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= bus.in_data;
    end else if (w_shift) begin
      r_shreg <= w_shreg_shifted;
    end
  end

endmodule

`default_nettype wire
